// File: rtl/spi_rom_fetch.sv
// spi_rom_fetch: SPI mode-0 byte fetch (03h read) from serial flash, keeping CS low
// between fetches so consecutive addresses stream without resending command/address.
module spi_rom_fetch #(
  parameter logic [7:0] ADDR_HI      = 8'h00,
  parameter int         IDLE_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [15:0] addr,
  output logic [7:0]  data_out,
  output logic        ready,
  output logic        busy,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);
  typedef enum logic [2:0] {IDLE, CS_GAP, CMD, ADDR, DATA, DONE, STREAM} state_t;
  localparam logic [15:0] IDLE_LAST = 16'(IDLE_TIMEOUT - 1);
  state_t state, state_n;
  logic [31:0] tx;
  logic [7:0] rx;
  logic [4:0] cnt;
  logic [15:0] lat, last_addr, idle_cnt;
  logic shifting, accept, seq;
  assign shifting = state inside {CMD, ADDR, DATA};
  assign accept = req && (state == IDLE || state == STREAM);
  assign seq = {1'b0, addr} == {1'b0, last_addr} + 17'd1;
  assign busy = !(state inside {IDLE, STREAM});
  assign spi_cs_n = state inside {IDLE, CS_GAP};
  assign spi_mosi = (state inside {CMD, ADDR}) && tx[31];
  // Bit-phase transitions happen on the edge that ends an SCK-high cycle.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = req ? CMD : IDLE;
      CS_GAP:  state_n = cnt == 5'd1 ? CMD : CS_GAP;
      CMD:     state_n = spi_sck && cnt == 5'd7 ? ADDR : CMD;
      ADDR:    state_n = spi_sck && cnt == 5'd23 ? DATA : ADDR;
      DATA:    state_n = spi_sck && cnt == 5'd7 ? DONE : DATA;
      DONE:    state_n = STREAM;
      STREAM:  state_n = req ? (seq ? DATA : CS_GAP) : idle_cnt == IDLE_LAST ? IDLE : STREAM;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_sck   <= 1'b0;
      ready     <= 1'b0;
      data_out  <= 8'h00;
      last_addr <= 16'h0000;
      idle_cnt  <= 16'h0000;
      cnt       <= 5'd0;
      tx        <= 32'h0;
      rx        <= 8'h00;
      lat       <= 16'h0000;
    end else begin
      spi_sck  <= shifting && !spi_sck;
      ready    <= state == DONE;
      idle_cnt <= (state == STREAM && !req) ? idle_cnt + 16'd1 : 16'd0;
      cnt      <= state_n != state ? 5'd0 : (state == CS_GAP || spi_sck) ? cnt + 5'd1 : cnt;
      if (accept) begin
        lat <= addr;
        tx  <= {8'h03, ADDR_HI, addr};
      end else if (spi_sck && state inside {CMD, ADDR}) tx <= {tx[30:0], 1'b0};
      if (spi_sck && state == DATA) rx <= {rx[6:0], spi_miso};
      if (state == DONE) begin
        data_out  <= rx;
        last_addr <= lat;
      end
    end
  end
endmodule
